// File: rtl/mux_arb_rr_pkg.sv
`default_nettype none
//==============================================================================
// Module      : mux_arb_rr_pkg
// Description : Shared definitions for the two-port weighted round-robin merge
//               stage: default word width and source-port encodings.
// Revision    : 1.0 - initial release
//==============================================================================
package mux_arb_rr_pkg;

    localparam int DATA_SIZE_DEF = 10;

    // Port encodings shared with the destination demux on the other side.
    typedef enum logic {
        PORT_F0 = 1'b0,
        PORT_F1 = 1'b1
    } port_e;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_F0) ? PORT_F1 : PORT_F0;
    endfunction

endpackage : mux_arb_rr_pkg
`default_nettype wire

// File: rtl/mux_arb_rr_if.sv
`default_nettype none
//==============================================================================
// Module      : mux_arb_rr_if
// Description : FIFO-side, downstream and debug signals of the merge stage.
// Revision    : 1.0 - initial release
//==============================================================================
interface mux_arb_rr_if
    import mux_arb_rr_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int CNT_WIDTH = 8
);
    logic [DATA_SIZE-1:0] data_f0;
    logic [DATA_SIZE-1:0] data_f1;
    logic                 empty_f0;
    logic                 empty_f1;
    logic                 pause;
    logic                 pop_f0;
    logic                 pop_f1;
    logic [DATA_SIZE-1:0] data_out;
    logic                 valid_out;
    logic                 src_out;
    logic [CNT_WIDTH-1:0] cnt_f0;
    logic [CNT_WIDTH-1:0] cnt_f1;

    // Environment side: owns the FIFOs and the downstream pause.
    modport master (
        output data_f0, data_f1, empty_f0, empty_f1, pause,
        input  pop_f0, pop_f1, data_out, valid_out, src_out, cnt_f0, cnt_f1
    );

    // Arbiter side.
    modport slave (
        input  data_f0, data_f1, empty_f0, empty_f1, pause,
        output pop_f0, pop_f1, data_out, valid_out, src_out, cnt_f0, cnt_f1
    );

endinterface : mux_arb_rr_if
`default_nettype wire

// File: rtl/mux_arb_rr_arb_sel.sv
`default_nettype none
//==============================================================================
// Module      : mux_arb_rr_arb_sel
// Description : Combinational keep/switch decode producing the FIFO pops.
// Revision    : 1.0 - initial release
//==============================================================================
module mux_arb_rr_arb_sel
    import mux_arb_rr_pkg::*;
#(
    parameter int QUANTUM = 2,
    parameter int QW      = 2
) (
    input  port_e           cur_i,
    input  logic [QW-1:0]   qcnt_i,
    input  logic            empty_f0_i,
    input  logic            empty_f1_i,
    input  logic            pause_i,
    input  logic            reset_L_i,
    output logic            pop_f0_o,
    output logic            pop_f1_o
);

    localparam logic [QW-1:0] QMAX = QW'(QUANTUM);

    logic w_empty_cur;
    logic w_empty_oth;
    logic w_keep;
    logic w_sw;
    logic w_en;

    always_comb begin
        w_empty_cur = (cur_i == PORT_F0) ? empty_f0_i : empty_f1_i;
        w_empty_oth = (cur_i == PORT_F0) ? empty_f1_i : empty_f0_i;
        // The quantum only limits the holder while the other port has work.
        w_keep      = ~w_empty_cur & ((qcnt_i < QMAX) | w_empty_oth);
        w_sw        = ~w_keep & ~w_empty_oth;
        w_en        = reset_L_i & ~pause_i;

        pop_f0_o    = w_en & ((w_keep & (cur_i == PORT_F0)) |
                              (w_sw   & (cur_i == PORT_F1)));
        pop_f1_o    = w_en & ((w_keep & (cur_i == PORT_F1)) |
                              (w_sw   & (cur_i == PORT_F0)));
    end

endmodule : mux_arb_rr_arb_sel
`default_nettype wire

// File: rtl/mux_arb_rr.sv
`default_nettype none
//==============================================================================
// Module      : mux_arb_rr
// Description : Weighted round-robin merge of two FWFT FIFOs into one
//               registered, source-tagged stream with per-port word counters.
// Revision    : 1.0 - initial release
//==============================================================================
module mux_arb_rr
    import mux_arb_rr_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int QUANTUM   = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset_L,
    mux_arb_rr_if.slave  bus
);

    localparam int            QW   = (QUANTUM < 1) ? 1 : $clog2(QUANTUM + 1);
    localparam logic [QW-1:0] QMAX = QW'(QUANTUM);

    port_e                cur_q,   cur_d;
    logic [QW-1:0]        qcnt_q,  qcnt_d;
    logic [DATA_SIZE-1:0] data_q,  data_d;
    logic                 valid_q, valid_d;
    port_e                src_q,   src_d;
    logic [CNT_WIDTH-1:0] cnt0_q,  cnt0_d;
    logic [CNT_WIDTH-1:0] cnt1_q,  cnt1_d;

    logic w_pop_f0;
    logic w_pop_f1;
    logic w_pop_any;
    logic w_pop_cur;

    mux_arb_rr_arb_sel #(
        .QUANTUM (QUANTUM),
        .QW      (QW)
    ) u_arb_sel (
        .cur_i      (cur_q),
        .qcnt_i     (qcnt_q),
        .empty_f0_i (bus.empty_f0),
        .empty_f1_i (bus.empty_f1),
        .pause_i    (bus.pause),
        .reset_L_i  (reset_L),
        .pop_f0_o   (w_pop_f0),
        .pop_f1_o   (w_pop_f1)
    );

    always_comb begin
        w_pop_any = w_pop_f0 | w_pop_f1;
        w_pop_cur = (cur_q == PORT_F0) ? w_pop_f0 : w_pop_f1;

        cur_d  = cur_q;
        qcnt_d = qcnt_q;
        if (w_pop_cur) begin
            qcnt_d = (qcnt_q == QMAX) ? QMAX : qcnt_q + QW'(1);
        end else if (w_pop_any) begin
            cur_d  = other_port(cur_q);
            qcnt_d = QW'(1);
        end

        // Idle cycles present zeros rather than the stale word.
        valid_d = w_pop_any;
        data_d  = '0;
        src_d   = PORT_F0;
        if (w_pop_f0) begin
            data_d = bus.data_f0;
        end else if (w_pop_f1) begin
            data_d = bus.data_f1;
            src_d  = PORT_F1;
        end

        cnt0_d = cnt0_q + CNT_WIDTH'(w_pop_f0);
        cnt1_d = cnt1_q + CNT_WIDTH'(w_pop_f1);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cur_q   <= PORT_F0;
            qcnt_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= PORT_F0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            cur_q   <= cur_d;
            qcnt_q  <= qcnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign bus.pop_f0    = w_pop_f0;
    assign bus.pop_f1    = w_pop_f1;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.src_out   = src_q;
    assign bus.cnt_f0    = cnt0_q;
    assign bus.cnt_f1    = cnt1_q;

endmodule : mux_arb_rr
`default_nettype wire
